// File: rtl/openrigil_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, one-entry valid/ready holding register and error pulses.
// Define UART_RX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) between data and stop.
module openrigil_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [15:0] LP_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || PARITY_ODD > 1) begin : g_bad_param
        $error("openrigil_uart_rx: CLKS_PER_BIT must be 4..65535 and PARITY_ODD 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      r_state;
    logic        r_s1;
    logic        r_rxd_s;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_frame_err;
    logic        r_overrun;
    logic        r_par_bad;

    logic        w_bit_end;
    logic        w_half_end;
    logic        w_par_bad;

    assign w_bit_end  = (r_cnt == LP_BIT_LAST);
    assign w_half_end = (r_cnt == LP_HALF_LAST);

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;
    // A mismatch is a received parity bit differing from XOR of data, inverted for odd sense.
    assign w_par_bad  = r_rxd_s ^ (^r_shift) ^ (PARITY_ODD != 0);
    assign parity_err = r_parity_err;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_s1        <= 1'b1;
            r_rxd_s     <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_idx       <= 3'd0;
            r_data      <= 8'd0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_par_bad   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_s1        <= rxd;
            r_rxd_s     <= r_s1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // A good byte landing this cycle overrides the consume below.
            if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt     <= 16'd0;
                    r_par_bad <= 1'b0;
                    if (!r_rxd_s) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (w_half_end) begin
                        r_cnt <= 16'd0;
                        if (r_rxd_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                            r_idx   <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= 16'd0;
                        r_shift <= {r_rxd_s, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt     <= 16'd0;
                        r_par_bad <= w_par_bad;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= 16'd0;
                        if (!r_rxd_s) begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end else begin
                            r_state <= S_IDLE;
                            if (r_par_bad) begin
`ifdef UART_RX_PARITY_EN
                                r_parity_err <= 1'b1;
`endif
                            end else if (!r_valid || ready) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_BREAK: begin
                    r_cnt <= 16'd0;
                    if (r_rxd_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_cnt   <= 16'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = (r_state != S_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_openrigil_uart_rx.sv
// Directed and randomized bench for openrigil_uart_rx at CLKS_PER_BIT=16 against a frame-level model.
module tb_openrigil_uart_rx;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int LAT = 2 + H + (9 + NPAR) * CPB;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    openrigil_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
        .clock(clock), .nreset(nreset), .rxd(rxd), .data(data), .valid(valid),
        .ready(ready), .busy(busy), .frame_err(frame_err), .overrun(overrun),
        .parity_err(parity_err)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    int   nchk = 0;
    int   npass = 0;
    int   nfail = 0;
    int   n_ferr, n_ovr, n_perr, rise_cyc, ovr_cyc;
    logic prev_valid = 1'b0;
    logic ready_base = 1'b0;
    logic m_valid;
    logic [7:0] m_data;

    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
        if (overrun) begin
            n_ovr++;
            ovr_cyc = cyc;
        end
        if (valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
        prev_valid = valid;
    endtask

    task automatic clear_stats();
        n_ferr = 0; n_ovr = 0; n_perr = 0; rise_cyc = -1; ovr_cyc = -1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame; rdy_i selects the edge (relative to T) at which ready is pulsed.
    task automatic send_frame(input logic [7:0] b, input logic par_v, input logic stop_v,
                              input int rdy_i, output int t_edge);
        logic v;
        t_edge = cyc + 1;
        for (int k = 0; k < 10 + NPAR; k++) begin
            if (k == 0)                   v = 1'b0;
            else if (k <= 8)              v = b[k-1];
            else if (k == 9 && NPAR == 1) v = par_v;
            else                          v = stop_v;
            for (int j = 0; j < CPB; j++) begin
                rxd   = v;
                ready = (rdy_i == k * CPB + j) ? 1'b1 : ready_base;
                tick();
            end
        end
        rxd   = 1'b1;
        ready = ready_base;
    endtask

    task automatic consume();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        m_valid = 1'b0;
        check("consume_valid", valid, 0);
    endtask

    initial begin
        int t, t2;
        logic [7:0] b;
        logic bad;
        m_valid = 1'b0;
        m_data  = 8'd0;
        clear_stats();

        nreset = 1'b0;
        repeat (3) tick();
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_perr", parity_err, 0);
        nreset = 1'b1;
        repeat (4) tick();

        clear_stats();
        send_frame(8'h55, ^8'h55, 1'b1, -1, t);
        check("b55_rise", rise_cyc, t + LAT);
        check("b55_data", data, 8'h55);
        check("b55_valid", valid, 1);
        check("b55_ferr", n_ferr, 0);
        check("b55_ovr", n_ovr, 0);
        consume();

        clear_stats();
        rxd = 1'b0;
        repeat (3) tick();
        check("glitch_busy_hi", busy, 1);
        repeat (2) tick();
        rxd = 1'b1;
        repeat (7) tick();
        check("glitch_busy_lo", busy, 0);
        check("glitch_valid", valid, 0);
        check("glitch_ferr", n_ferr, 0);

        clear_stats();
        send_frame(8'hA3, ^8'hA3, 1'b0, -1, t);
        rxd = 1'b0;
        repeat (300) tick();
        rxd = 1'b1;
        repeat (6) tick();
        check("brk_ferr", n_ferr, 1);
        check("brk_valid", rise_cyc, -1);
        check("brk_busy", busy, 0);
        check("brk_perr", n_perr, 0);
        clear_stats();
        send_frame(8'h3C, ^8'h3C, 1'b1, -1, t);
        check("b3c_data", data, 8'h3C);
        check("b3c_rise", rise_cyc, t + LAT);
        check("b3c_ferr", n_ferr, 0);
        consume();

        clear_stats();
        send_frame(8'h11, ^8'h11, 1'b1, -1, t);
        send_frame(8'h22, ^8'h22, 1'b1, -1, t2);
        check("ovr_data", data, 8'h11);
        check("ovr_valid", valid, 1);
        check("ovr_count", n_ovr, 1);
        check("ovr_cyc", ovr_cyc, t2 + LAT);
        consume();

        clear_stats();
        send_frame(8'h11, ^8'h11, 1'b1, -1, t);
        send_frame(8'h22, ^8'h22, 1'b1, LAT, t2);
        check("rdy_data", data, 8'h22);
        check("rdy_valid", valid, 1);
        check("rdy_ovr", n_ovr, 0);
        consume();

        send_frame(8'h5A, ^8'h5A, 1'b1, -1, t);
        check("pre_rst_valid", valid, 1);
        rxd = 1'b0;
        repeat (CPB) tick();
        rxd = 1'b1;
        repeat (4 * CPB + H) tick();
        nreset = 1'b0;
        repeat (2) tick();
        check("mid_rst_data", data, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        nreset = 1'b1;
        repeat (6 * CPB) tick();
        clear_stats();
        send_frame(8'h81, ^8'h81, 1'b1, -1, t);
        check("b81_data", data, 8'h81);
        check("b81_rise", rise_cyc, t + LAT);
        check("b81_ferr", n_ferr, 0);
        consume();

        for (int i = 0; i < 10; i++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            clear_stats();
            send_frame(b, ^b, !bad, -1, t);
            repeat (4) tick();
            check("rnd_ferr", n_ferr, {31'd0, bad});
            check("rnd_ovr", n_ovr, {31'd0, (!bad && m_valid)});
            if (!bad && !m_valid) begin
                m_valid = 1'b1;
                m_data  = b;
            end
            check("rnd_valid", valid, {31'd0, m_valid});
            check("rnd_busy", busy, 0);
            if (m_valid) check("rnd_data", data, m_data);
            if ($urandom_range(0, 1) == 1) consume();
        end
        if (m_valid) consume();

`ifdef UART_RX_PARITY_EN
        clear_stats();
        send_frame(8'h07, 1'b1, 1'b1, -1, t);
        check("par_ok_valid", valid, 1);
        check("par_ok_data", data, 8'h07);
        check("par_ok_perr", n_perr, 0);
        consume();
        clear_stats();
        send_frame(8'h07, 1'b0, 1'b1, -1, t);
        check("par_bad_perr", n_perr, 1);
        check("par_bad_valid", valid, 0);
        check("par_bad_ovr", n_ovr, 0);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/openrigil_uart_rx.md
Name: openrigil_uart_rx

Overview:
- 8N1 UART receiver for the board-level OpenRigil wrapper. It drives the SoC-side `uart_0_rxd` path from the board RX pin.
- Synchronises the asynchronous `rxd` pin, validates the start bit at mid-bit and samples 8 data bits LSB-first at mid-bit. It then checks the stop bit and presents each byte through a one-entry valid/ready holding register.
- Reports framing and overrun errors as one-cycle pulses.

Parameters:
- CLKS_PER_BIT, 234, clock cycles per bit (27 MHz / 115200). Legal range is 4..65535. Let H = floor(CLKS_PER_BIT/2).
- PARITY_ODD, 0, parity sense. 0 = even, 1 = odd. Used only with the optional feature.

Ports:
- clock  in  1  sole clock; all logic is on its rising edge.
- nreset  in  1  reset, synchronous and active-low.
- rxd  in  1  asynchronous serial input; idles high.
- data  out  8  received byte; valid only while `valid`=1.
- valid  out  1  holding register full.
- ready  in  1  consumer accepts `data` on a cycle where valid&&ready.
- busy  out  1  high in every state other than IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good byte dropped because the holding register was full.
- parity_err  out  1  one-cycle pulse: parity mismatch. Tied 0 without the optional feature.

Behaviour:
- Reset (nreset=0 at a clock edge): data=0, valid=0, busy=0, frame_err=0, overrun=0, parity_err=0.
  - Both synchroniser flops are set to 1. State=IDLE, bit counter=0, cycle counter=0.
  - Reset mid-frame aborts the frame with no error pulse. A held byte is discarded.
- Synchroniser: 2 flops, rxd -> s1 -> rxd_s. The FSM sees only rxd_s, 2 cycles after the pin.
- Cycle counter cnt is 16 bits. It clears on every state change and on every bit sample.
- IDLE: on an edge where rxd_s=0, go to START with cnt=0. Call this edge E0.
- START: count up. At cnt==H-1 (edge E0+H), sample rxd_s:
  - 1 -> glitch: return to IDLE silently.
  - 0 -> go to DATA with bit index 0.
- DATA: at cnt==CLKS_PER_BIT-1, shift rxd_s into bit[index] (LSB first). Data bit k (0..7) is sampled at E0+H+(k+1)*CLKS_PER_BIT. After bit 7, go to STOP (or PARITY when enabled).
- STOP: sample at cnt==CLKS_PER_BIT-1, i.e. edge E0+H+9*CLKS_PER_BIT.
  - 1 -> good byte.
  - 0 -> frame_err pulses for 1 cycle, the byte is discarded, and the FSM goes to BREAK.
  - On a good byte, go to IDLE at that same edge. The next start bit may begin in the second half of the stop bit.
- BREAK: wait until rxd_s=1, then go to IDLE. A held-low line produces exactly one frame_err.
- Holding register, evaluated on the good-byte edge:
  - valid=0: load data, valid=1.
  - valid=1 and ready=1 on that same cycle: old byte is consumed, new byte is loaded, valid stays 1, no overrun.
  - valid=1 and ready=0: keep the old byte and pulse overrun for 1 cycle.
  - Otherwise valid&&ready clears valid on the next edge. `data` is stable while valid=1.
- Latency: a rxd falling edge meeting setup at edge T gives valid=1 after edge T+2+H+9*CLKS_PER_BIT. With parity enabled this becomes T+2+H+10*CLKS_PER_BIT.
- Error pulses never coincide with valid rising for the same frame.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. The parity bit is sampled at E0+H+9*CLKS_PER_BIT and checked against the XOR of the 8 data bits (XNOR when PARITY_ODD=1).
  - On mismatch, parity_err pulses at the stop-sample edge, the byte is discarded, and there is no overrun. frame_err takes priority if both errors apply; only frame_err pulses.
- Undefined: there is no PARITY state, parity_err is constant 0, and the frame is 8N1 exactly.

Test Plan (CLKS_PER_BIT=16, H=8):
- Reset, then drive 0x55 8N1 with rxd falling before edge T -> data=0x55, valid=1 from T+154, no error pulses. With ready=1, valid drops on the following edge.
- Low pulse of 5 cycles on idle rxd -> no valid, no frame_err, busy returns to 0 within 12 cycles of the fall.
- Frame 0xA3 with stop bit low, then rxd held low 300 cycles -> exactly one frame_err pulse, valid stays 0, next good 0x3C is received correctly.
- ready=0, send 0x11 then 0x22 back to back -> data=0x11 held, one overrun pulse at the 0x22 stop sample. With ready=1 at that edge instead -> data=0x22, valid stays 1, no overrun.
- Assert nreset=0 mid-frame at bit 4 of 0xFF, then release -> all outputs 0, next frame 0x81 is received correctly.
- UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity 1 -> valid. Send 0x07 with parity 0 -> parity_err pulse, valid=0.
